// File: rtl/muldiv_pkg.sv
// Shared encodings and constants for the RV32M multiply/divide sequencer.
package muldiv_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam logic [31:0] DIV_OVF_DIVIDEND = 32'h8000_0000;

  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_FIXUP = 2'd2,
    ST_DONE  = 2'd3
  } md_state_e;

  function automatic logic isDivOp(input logic [2:0] opCode);
    return opCode[2];
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the unsigned datapath: shift-add multiply or restoring divide.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic              i_isDiv,
  input  logic [2*XLEN-1:0] i_acc,
  input  logic [XLEN-1:0]   i_operand,
  output logic [2*XLEN-1:0] o_acc,
  output logic              o_qBit
);

  logic [XLEN-1:0] w_hi;
  logic [XLEN-1:0] w_lo;
  logic [XLEN:0]   w_sum;
  logic [XLEN:0]   w_trial;

  assign w_hi    = i_acc[2*XLEN-1:XLEN];
  assign w_lo    = i_acc[XLEN-1:0];
  assign w_sum   = {1'b0, w_hi} + {1'b0, i_operand};
  // Partial remainder stays below the divisor, so bit XLEN of the trial is a clean borrow flag.
  assign w_trial = {w_hi, w_lo[XLEN-1]} - {1'b0, i_operand};

  always_comb begin
    o_acc  = '0;
    o_qBit = 1'b0;
    if (i_isDiv) begin
      o_qBit = ~w_trial[XLEN];
      if (o_qBit) o_acc = {w_trial[XLEN-1:0], w_lo[XLEN-2:0], 1'b0};
      else        o_acc = {w_hi[XLEN-2:0], w_lo, 1'b0};
    end else begin
      if (w_lo[0]) o_acc = {w_sum, w_lo[XLEN-1:1]};
      else         o_acc = {1'b0, w_hi, w_lo[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// RV32M multiply/divide sequencer: one bit per cycle, stalls execute, pulses done.
// Optional MULDIV_EARLY_OUT_EN: zero multiply operand or zero divisor skips CALC.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1_value,
  input  logic [XLEN-1:0] rs2_value,
  input  logic [4:0]      in_RegDest,
  input  logic            flush,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      out_RegDest,
  output logic            out_RegWrite
);

  localparam int CNT_W = $clog2(XLEN) + 1;

  md_state_e         r_state, w_nextState;
  md_op_e            r_op;
  logic [CNT_W-1:0]  r_count;
  logic [2*XLEN-1:0] r_acc, w_accNext, w_prod;
  logic [XLEN-1:0]   r_operand, r_dividend, r_result;
  logic [XLEN-1:0]   w_absA, w_absB, w_quot, w_rem, w_fixResult;
  logic [4:0]        r_rd;
  logic              r_neg, r_divZero, r_divOvf, r_regWrite;
  logic              w_accept, w_aNeg, w_bNeg, w_isRem, w_skip, w_mulZero, w_qBit;

  assign w_accept = (r_state == ST_IDLE) & start & ~flush;
  assign w_aNeg   = (op inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM}) & rs1_value[XLEN-1];
  assign w_bNeg   = (op inside {MD_MULH, MD_DIV, MD_REM}) & rs2_value[XLEN-1];
  assign w_isRem  = op inside {MD_REM, MD_REMU};
  assign w_absA   = w_aNeg ? -rs1_value : rs1_value;
  assign w_absB   = w_bNeg ? -rs2_value : rs2_value;

`ifdef MULDIV_EARLY_OUT_EN
  logic r_mulZero;
  assign w_skip    = isDivOp(op) ? (rs2_value == '0) : ((rs1_value == '0) || (rs2_value == '0));
  assign w_mulZero = r_mulZero;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          r_mulZero <= 1'b0;
    else if (w_accept) r_mulZero <= (rs1_value == '0) || (rs2_value == '0);
  end
`else
  assign w_skip    = 1'b0;
  assign w_mulZero = 1'b0;
`endif

  muldiv_step #(.XLEN(XLEN)) u_step (
    .i_isDiv   (isDivOp(r_op)),
    .i_acc     (r_acc),
    .i_operand (r_operand),
    .o_acc     (w_accNext),
    .o_qBit    (w_qBit)
  );

  always_comb begin
    w_nextState = r_state;
    stall       = 1'b0;
    busy        = (r_state != ST_IDLE);
    done        = (r_state == ST_DONE);
    case (r_state)
      ST_IDLE: begin
        stall = start & ~flush;
        if (w_accept) w_nextState = w_skip ? ST_FIXUP : ST_CALC;
      end
      ST_CALC: begin
        stall = 1'b1;
        if (flush)                               w_nextState = ST_IDLE;
        else if (r_count == CNT_W'(XLEN - 1))    w_nextState = ST_FIXUP;
      end
      ST_FIXUP: begin
        stall       = 1'b1;
        w_nextState = flush ? ST_IDLE : ST_DONE;
      end
      ST_DONE: w_nextState = ST_IDLE;
    endcase
  end

  // Magnitudes were iterated unsigned; restore the sign, then apply RV32M corner cases.
  assign w_prod = r_neg ? -r_acc : r_acc;
  assign w_quot = r_neg ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
  assign w_rem  = r_neg ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];

  always_comb begin
    w_fixResult = w_prod[XLEN-1:0];
    case (r_op)
      MD_MUL:                       w_fixResult = w_prod[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: w_fixResult = w_prod[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU: begin
        if (r_divZero)                        w_fixResult = '1;
        else if (r_op == MD_DIV && r_divOvf)  w_fixResult = DIV_OVF_DIVIDEND;
        else                                  w_fixResult = w_quot;
      end
      MD_REM, MD_REMU: begin
        if (r_divZero)                        w_fixResult = r_dividend;
        else if (r_op == MD_REM && r_divOvf)  w_fixResult = '0;
        else                                  w_fixResult = w_rem;
      end
    endcase
    if (w_mulZero && !isDivOp(r_op)) w_fixResult = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_op       <= MD_MUL;
      r_count    <= '0;
      r_acc      <= '0;
      r_operand  <= '0;
      r_dividend <= '0;
      r_neg      <= 1'b0;
      r_divZero  <= 1'b0;
      r_divOvf   <= 1'b0;
      r_rd       <= '0;
      r_result   <= '0;
      r_regWrite <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_regWrite <= 1'b0;
      if (w_accept) begin
        r_op       <= md_op_e'(op);
        r_acc      <= {{XLEN{1'b0}}, w_absA};
        r_operand  <= w_absB;
        r_dividend <= rs1_value;
        r_neg      <= w_isRem ? w_aNeg : (w_aNeg ^ w_bNeg);
        r_divZero  <= (rs2_value == '0);
        r_divOvf   <= (rs1_value == DIV_OVF_DIVIDEND) && (rs2_value == '1);
        r_count    <= '0;
        r_rd       <= in_RegDest;
      end else if (r_state == ST_CALC) begin
        r_acc   <= isDivOp(r_op) ? {w_accNext[2*XLEN-1:1], w_qBit} : w_accNext;
        r_count <= r_count + CNT_W'(1);
      end
      if (r_state == ST_FIXUP && !flush) begin
        r_result   <= w_fixResult;
        r_regWrite <= (r_rd != 5'd0);
      end
    end
  end

  assign result       = r_result;
  assign out_RegDest  = r_rd;
  assign out_RegWrite = r_regWrite;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: arithmetic reference model plus directed vectors.
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

`ifdef MULDIV_EARLY_OUT_EN
  localparam int ZLAT = 2;
`else
  localparam int ZLAT = 34;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] rs1_value = '0;
  logic [31:0] rs2_value = '0;
  logic [4:0]  in_RegDest = '0;
  logic        flush = 1'b0;
  logic        busy, stall, done, out_RegWrite;
  logic [31:0] result;
  logic [4:0]  out_RegDest;

  int checks = 0;
  int errors = 0;
  int edgeNum = 0;
  int acceptEdge = 0;
  int k = 0;

  // Reference model state: one op in flight, counted in edges since acceptance.
  bit          mActive = 1'b0;
  int          mElapsed = 0;
  int          mLat = 34;
  logic [31:0] mPend = '0;
  logic [31:0] mResult = '0;
  logic [4:0]  mRd = '0;

  muldiv_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .rs1_value(rs1_value), .rs2_value(rs2_value), .in_RegDest(in_RegDest),
    .flush(flush), .busy(busy), .stall(stall), .done(done), .result(result),
    .out_RegDest(out_RegDest), .out_RegWrite(out_RegWrite)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] refResult(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [63:0] ua, ub, p;
    int ia, ib;
    bit ovf;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    ia = a;
    ib = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (o)
      3'b000: begin p = ua * ub; return p[31:0]; end
      3'b001: begin p = sa * sb; return p[63:32]; end
      3'b010: begin p = sa * ub; return p[63:32]; end
      3'b011: begin p = ua * ub; return p[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        return ia / ib;
      end
      3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int refLatency(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
    if (o[2] ? (b == 0) : (a == 0 || b == 0)) return 2;
`endif
    return 34;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at edge %0d: got %h expected %h", name, edgeNum, act, exp);
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mActive = 1'b0;
      mResult = '0;
      mRd     = '0;
    end else begin
      edgeNum++;
      if (mActive) begin
        if (mElapsed == mLat - 1) mActive = 1'b0;
        else if (flush)           mActive = 1'b0;
        else begin
          mElapsed++;
          if (mElapsed == mLat - 1) mResult = mPend;
        end
      end else if (start && !flush) begin
        mActive  = 1'b1;
        mElapsed = 0;
        mLat     = refLatency(op, rs1_value, rs2_value);
        mPend    = refResult(op, rs1_value, rs2_value);
        mRd      = in_RegDest;
      end
    end
  end

  // Every cycle, all outputs must match the model.
  always @(negedge clk) begin
    bit expDone;
    expDone = mActive && (mElapsed == mLat - 1);
    check("busy", busy, mActive);
    check("done", done, expDone);
    check("stall", stall, (start && !flush && !mActive) || (mActive && mElapsed < mLat - 1));
    check("result", result, mResult);
    check("out_RegDest", out_RegDest, mRd);
    check("out_RegWrite", out_RegWrite, expDone && (mRd != 0));
  end

  task automatic applyStimulus(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    @(posedge clk); #1;
    start = 1'b1; op = o; rs1_value = a; rs2_value = b; in_RegDest = rd;
    @(posedge clk); #1;
    start = 1'b0;
    acceptEdge = edgeNum;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] expResult, input int expLat, input logic expWr);
    int waited = 0;
    bit seen = 1'b0;
    while (!seen && waited < 60) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
      else waited++;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s done timeout: got no done, expected done after %0d edges", name, expLat);
    end else begin
      check({name, " latency"}, edgeNum + 1 - acceptEdge, expLat);
      check({name, " result"}, result, expResult);
      check({name, " regwrite"}, out_RegWrite, expWr);
    end
  endtask

  initial begin
    int seenDone;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset result", result, 32'h0);
    check("reset regwrite", out_RegWrite, 1'b0);
    @(posedge clk); #1 rst = 1'b1;

    applyStimulus(MD_MUL, 32'h7, 32'hFFFF_FFFD, 5'd5);
    checkOutput("MUL 7x-3", 32'hFFFF_FFEB, 34, 1'b1);
    check("MUL rd", out_RegDest, 5'd5);
    applyStimulus(MD_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6);
    checkOutput("MULHU", 32'hFFFF_FFFE, 34, 1'b1);
    applyStimulus(MD_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6);
    checkOutput("MULH", 32'h0, 34, 1'b1);
    applyStimulus(MD_MULHSU, 32'hFFFF_FFFE, 32'h3, 5'd7);
    checkOutput("MULHSU", 32'hFFFF_FFFF, 34, 1'b1);
    applyStimulus(MD_DIV, 32'hFFFF_FFF9, 32'h2, 5'd8);
    checkOutput("DIV -7/2", 32'hFFFF_FFFD, 34, 1'b1);
    applyStimulus(MD_REM, 32'hFFFF_FFF9, 32'h2, 5'd8);
    checkOutput("REM -7/2", 32'hFFFF_FFFF, 34, 1'b1);
    applyStimulus(MD_DIVU, 32'd100, 32'd0, 5'd9);
    checkOutput("DIVU by 0", 32'hFFFF_FFFF, ZLAT, 1'b1);
    applyStimulus(MD_REMU, 32'd100, 32'd0, 5'd9);
    checkOutput("REMU by 0", 32'd100, ZLAT, 1'b1);
    applyStimulus(MD_DIVU, 32'd100, 32'd7, 5'd10);
    checkOutput("DIVU 100/7", 32'd14, 34, 1'b1);
    applyStimulus(MD_REMU, 32'd100, 32'd7, 5'd10);
    checkOutput("REMU 100/7", 32'd2, 34, 1'b1);
    applyStimulus(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11);
    checkOutput("DIV ovf", 32'h8000_0000, 34, 1'b1);
    applyStimulus(MD_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11);
    checkOutput("REM ovf", 32'h0, 34, 1'b1);

    // Flush mid-CALC, then a fresh op two edges later.
    applyStimulus(MD_DIVU, 32'd1000, 32'd3, 5'd12);
    k = acceptEdge;
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    check("stall before flush edge", stall, 1'b1);
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    check("stall after flush", stall, 1'b0);
    check("busy after flush", busy, 1'b0);
    @(posedge clk); #1;
    start = 1'b1; op = MD_MUL; rs1_value = 32'd3; rs2_value = 32'd4; in_RegDest = 5'd13;
    @(negedge clk);
    check("stall on new start", stall, 1'b1);
    @(posedge clk); #1 start = 1'b0;
    acceptEdge = edgeNum;
    check("restart edge", acceptEdge - k, 12);
    checkOutput("MUL after flush", 32'd12, 34, 1'b1);

    // Back-to-back: start held high; second op accepted right after DONE.
    @(posedge clk); #1;
    start = 1'b1; op = MD_MUL; rs1_value = 32'd2; rs2_value = 32'd3; in_RegDest = 5'd14;
    @(posedge clk); #1;
    acceptEdge = edgeNum;
    rs1_value = 32'd4; rs2_value = 32'd5; in_RegDest = 5'd15;
    repeat (33) @(posedge clk);
    @(negedge clk);
    check("b2b first done", done, 1'b1);
    check("b2b first result", result, 32'd6);
    check("b2b first rd", out_RegDest, 5'd14);
    repeat (2) @(posedge clk);
    #1 start = 1'b0;
    acceptEdge = edgeNum;
    checkOutput("b2b second", 32'd20, 34, 1'b1);

    // start while busy must be ignored.
    applyStimulus(MD_MUL, 32'd6, 32'd7, 5'd16);
    repeat (4) @(posedge clk);
    #1 start = 1'b1; op = MD_DIVU; rs1_value = 32'd99; rs2_value = 32'd0; in_RegDest = 5'd17;
    @(posedge clk); #1 start = 1'b0;
    checkOutput("ignored start", 32'd42, 34, 1'b1);
    check("ignored start rd", out_RegDest, 5'd16);

    applyStimulus(MD_MUL, 32'd9, 32'd9, 5'd0);
    checkOutput("MUL rd0", 32'd81, 34, 1'b0);

    // Asynchronous reset mid-op discards it.
    applyStimulus(MD_MUL, 32'd5, 32'd6, 5'd18);
    repeat (19) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("mid reset busy", busy, 1'b0);
    check("mid reset done", done, 1'b0);
    check("mid reset regwrite", out_RegWrite, 1'b0);
    check("mid reset result", result, 32'h0);
    @(posedge clk); #1 rst = 1'b1;
    seenDone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) seenDone++;
    end
    check("no done after reset", seenDone, 0);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
